// File: rtl/pipe_stage_reg.sv
// Purpose : pipeline stage register between two stages, with a flush (bubble) input and bubble/stall counters.
// Latency : 1 cycle from acceptance to the output. Define PIPE_STAGE_SKID_EN for a two-entry (main plus skid) stage.
// Backpressure : single entry: in_ready = !out_valid | out_ready. Skid: in_ready is a flop, with no path from out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 3,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_W-1:0]  in_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_W-1:0]  out_reg,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENT_W = DATA_W + CTRL_W + REG_W;

    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] out_ent;
    logic             accept;
    logic             retire;

    assign in_ent = {in_data, in_ctrl, in_reg};
    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // The payload is forced to zero whenever nothing valid is presented.
    assign {out_data, out_ctrl, out_reg} = out_valid ? out_ent : '0;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;

    // in_ready comes from a flop. Only reset and flush can gate it, never out_ready.
    assign in_ready  = in_ready_q & ~flush & ~reset;
    assign out_valid = (state_q != EMPTY);
    assign out_ent   = main_q;

    // Compute the next state. The skid entry takes an accept that arrives while main is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    main_d = in_ent;
                end else if (accept) begin
                    skid_d  = in_ent;
                    state_d = TWO;
                end else if (retire) begin
                    main_d  = '0;
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (retire) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        in_ready_d = (state_d != TWO);
    end

    // Register the FSM, both entries and the ready flop. Reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    logic             valid_q, valid_d;
    logic [ENT_W-1:0] ent_q, ent_d;

    // A single entry can still stream at one per cycle because retire and accept overlap.
    assign in_ready  = (~valid_q | out_ready) & ~flush & ~reset;
    assign out_valid = valid_q;
    assign out_ent   = ent_q;

    // Compute the next entry. Flush drops the held entry and any input in the same cycle.
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        if (flush) begin
            valid_d = 1'b0;
            ent_d   = '0;
        end else begin
            if (retire) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                valid_d = 1'b1;
                ent_d   = in_ent;
            end
        end
    end

    // Register the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end
`endif

    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;

    // Statistics. Counters saturate at all-ones and never wrap.
    always_comb begin
        bubble_d = bubble_q;
        stall_d  = stall_q;
        if (!out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Register the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
        end
    end

endmodule
